demux_sequencer: RTL and testbench

Time-division sequencer that drives the select and data inputs of the 1-to-8 `demux` block. It accepts single data bits from an upstream producer over a valid/ready handshake and routes each bit to the next enabled output channel in ascending round-robin order. Each bit is held stable on the demux for a programmable settle time, then a one-hot strobe tells the channel to latch it. Sits between a serial source and eight per-channel capture registers.

---
 rtl/demux_sequencer_if.sv | 40 ++++
 rtl/demux_sequencer.sv | 159 +++++++++++++++
 tb/tb_demux_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/demux_sequencer_if.sv
// Bundle of the upstream handshake and the demux drive signals for demux_sequencer.
// The sequencer connects through the slave modport. The producer/demux side uses the master modport.
interface demux_sequencer_if #(
    parameter int N_CH  = 8,
    parameter int SEL_W = 3
);
    logic [N_CH-1:0]  en_mask;
    logic             in_valid;
    logic             in_data;
    logic             in_ready;
    logic [SEL_W-1:0] sel;
    logic             d;
    logic [N_CH-1:0]  strobe;
    logic             frame_done;
    logic             busy;

    modport slave (
        input  en_mask,
        input  in_valid,
        input  in_data,
        output in_ready,
        output sel,
        output d,
        output strobe,
        output frame_done,
        output busy
    );

    modport master (
        output en_mask,
        output in_valid,
        output in_data,
        input  in_ready,
        input  sel,
        input  d,
        input  strobe,
        input  frame_done,
        input  busy
    );
endinterface

// File: rtl/demux_sequencer.sv
// Time-division sequencer feeding a 1-to-8 demux.
// Each accepted bit goes to the next enabled channel in round-robin order. The bit is held
// for HOLD_CYCLES settle cycles, then a one-hot strobe latches it into its channel.
module demux_sequencer #(
    parameter int N_CH        = 8,
    parameter int SEL_W       = 3,
    parameter int HOLD_CYCLES = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    demux_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_STRB = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

    state_t           r_state;
    state_t           w_stateNext;

    logic [SEL_W-1:0] r_ptr;
    logic [3:0]       r_hcnt;
    logic             r_last;
    logic [SEL_W-1:0] r_sel;
    logic             r_d;
    logic [N_CH-1:0]  r_strobe;
    logic             r_frameDone;
    logic             r_busy;

    logic [SEL_W-1:0] w_ch;
    logic             w_found;
    logic             w_last;
    logic             w_inReady;
    logic             w_accept;
    logic [N_CH-1:0]  w_strobeOneHot;

    // Ready only in IDLE with at least one channel enabled; accept is the handshake edge.
    assign w_inReady = (r_state == ST_IDLE) && (|bus.en_mask);
    assign w_accept  = w_inReady && bus.in_valid;

    // The strobe is decoded from the frozen select, so no input reaches it combinationally.
    assign w_strobeOneHot = {{(N_CH-1){1'b0}}, 1'b1} << r_sel;

    // Round-robin search: first enabled channel at or after ptr, wrapping modulo N_CH.
    always_comb begin
        logic [SEL_W-1:0] w_idx;
        w_found = 1'b0;
        w_ch    = '0;
        w_idx   = '0;
        for (int k = 0; k < N_CH; k++) begin
            w_idx = r_ptr + SEL_W'(k);
            if (!w_found && bus.en_mask[w_idx]) begin
                w_found = 1'b1;
                w_ch    = w_idx;
            end
        end
    end

    // The chosen channel closes a frame when no enabled channel sits above it.
    always_comb begin
        w_last = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            if ((i > int'(w_ch)) && bus.en_mask[i]) begin
                w_last = 1'b0;
            end
        end
    end

    // State register with asynchronous abort on reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic: accept, settle for HOLD_CYCLES, strobe for exactly one cycle.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_stateNext = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (r_hcnt == 4'd0) begin
                    w_stateNext = ST_STRB;
                end
            end
            ST_STRB: begin
                w_stateNext = ST_IDLE;
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // Datapath: capture on accept, count down the hold, pulse strobe, then clear data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr       <= '0;
            r_hcnt      <= '0;
            r_last      <= 1'b0;
            r_sel       <= '0;
            r_d         <= 1'b0;
            r_strobe    <= '0;
            r_frameDone <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_sel  <= w_ch;
                        r_d    <= bus.in_data;
                        r_last <= w_last;
                        r_ptr  <= w_ch + 1'b1;
                        r_hcnt <= HOLD_LOAD;
                        r_busy <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (r_hcnt == 4'd0) begin
                        r_strobe    <= w_strobeOneHot;
                        r_frameDone <= r_last;
                    end else begin
                        r_hcnt <= r_hcnt - 4'd1;
                    end
                end
                ST_STRB: begin
                    r_strobe    <= '0;
                    r_frameDone <= 1'b0;
                    r_d         <= 1'b0;
                    r_busy      <= 1'b0;
                end
                default: begin
                    r_strobe    <= '0;
                    r_frameDone <= 1'b0;
                    r_d         <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = w_inReady;
    assign bus.sel        = r_sel;
    assign bus.d          = r_d;
    assign bus.strobe     = r_strobe;
    assign bus.frame_done = r_frameDone;
    assign bus.busy       = r_busy;

endmodule

// File: tb/tb_demux_sequencer.sv
// Randomized self-checking bench for demux_sequencer.
// A transaction-level model tracks the round-robin pointer and predicts the channel,
// the frame-end flag and the timing of each transfer.
module tb_demux_sequencer;

    localparam int HOLD = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   checks   = 0;
    int   failures = 0;
    int   mPtr     = 0;

    demux_sequencer_if bus ();

    demux_sequencer #(
        .N_CH        (8),
        .SEL_W       (3),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter used to measure accept spacing.
    always @(posedge clk) cyc <= cyc + 1;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired got=timeout want=finish");
        $fatal(1, "[TB] watchdog");
    end

    // Model: first enabled channel at or after ptr, wrapping.
    function automatic int pickCh(input logic [7:0] mask, input int ptr);
        for (int k = 0; k < 8; k++) begin
            if (mask[(ptr + k) % 8]) return (ptr + k) % 8;
        end
        return -1;
    endfunction

    // Model: a channel ends the frame when it is the highest enabled one.
    function automatic bit isLast(input logic [7:0] mask, input int ch);
        int hi;
        hi = -1;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i] && hi < 0) hi = i;
        end
        return (ch == hi);
    endfunction

    // One full transfer: present a bit, follow it through hold, strobe and return to idle.
    task automatic transfer(input logic bitIn, input logic [7:0] mask, input logic [7:0] midMask,
                            input string tag, output int obsSel, output logic [7:0] obsDemux,
                            output int acceptCyc);
        int expCh;
        bit expLast;
        int n;
        obsSel    = -1;
        obsDemux  = 8'hxx;
        acceptCyc = -1;
        bus.en_mask  = mask;
        bus.in_valid = 1'b1;
        bus.in_data  = bitIn;
        #1;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL %s accept_wait in_ready got=%b want=1", tag, bus.in_ready);
            bus.in_valid = 1'b0;
            return;
        end
        expCh   = pickCh(mask, mPtr);
        expLast = isLast(mask, expCh);
        @(posedge clk);
        #1;
        acceptCyc = cyc;
        mPtr = (expCh + 1) % 8;
        for (int i = 0; i < HOLD; i++) begin
            @(negedge clk);
            checks++;
            if (bus.sel !== 3'(expCh)) begin
                failures++;
                $display("[TB] FAIL %s hold%0d sel got=%0d want=%0d", tag, i, bus.sel, expCh);
            end
            checks++;
            if (bus.d !== bitIn) begin
                failures++;
                $display("[TB] FAIL %s hold%0d d got=%b want=%b", tag, i, bus.d, bitIn);
            end
            checks++;
            if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
                failures++;
                $display("[TB] FAIL %s hold%0d busy/ready got=%b/%b want=1/0", tag, i, bus.busy, bus.in_ready);
            end
            checks++;
            if (bus.strobe !== 8'h00 || bus.frame_done !== 1'b0) begin
                failures++;
                $display("[TB] FAIL %s hold%0d strobe/fd got=%h/%b want=00/0", tag, i, bus.strobe, bus.frame_done);
            end
            if (i == 0) begin
                obsSel   = int'(bus.sel);
                obsDemux = bus.d ? (8'h01 << bus.sel) : 8'h00;
                bus.en_mask = midMask;
            end
            bus.in_valid = 1'($urandom);
            bus.in_data  = 1'($urandom);
        end
        @(negedge clk);
        checks++;
        if (bus.strobe !== (8'h01 << expCh)) begin
            failures++;
            $display("[TB] FAIL %s strobe got=%h want=%h", tag, bus.strobe, 8'h01 << expCh);
        end
        checks++;
        if (bus.frame_done !== expLast) begin
            failures++;
            $display("[TB] FAIL %s frame_done got=%b want=%b", tag, bus.frame_done, expLast);
        end
        checks++;
        if (bus.sel !== 3'(expCh) || bus.d !== bitIn || bus.busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL %s strb sel/d/busy got=%0d/%b/%b want=%0d/%b/1", tag, bus.sel, bus.d, bus.busy, expCh, bitIn);
        end
        bus.in_valid = 1'($urandom);
        @(negedge clk);
        checks++;
        if (bus.strobe !== 8'h00 || bus.frame_done !== 1'b0 || bus.d !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s idle strobe/fd/d/busy got=%h/%b/%b/%b want=00/0/0/0", tag, bus.strobe, bus.frame_done, bus.d, bus.busy);
        end
        checks++;
        if (bus.in_ready !== (|midMask)) begin
            failures++;
            $display("[TB] FAIL %s idle in_ready got=%b want=%b", tag, bus.in_ready, |midMask);
        end
        bus.in_valid = 1'b0;
    endtask

    // Asynchronous reset clears outputs between edges; release gives an idle, ready block.
    task automatic test_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.sel !== 3'd0 || bus.d !== 1'b0 || bus.strobe !== 8'h00 || bus.frame_done !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_async sel/d/strobe/fd/busy got=%0d/%b/%h/%b/%b want=0/0/00/0/0", bus.sel, bus.d, bus.strobe, bus.frame_done, bus.busy);
        end
        repeat (3) @(negedge clk);
        bus.en_mask  = 8'hFF;
        bus.in_valid = 1'b0;
        bus.in_data  = 1'b0;
        rst_n = 1'b1;
        mPtr  = 0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.sel !== 3'd0 || bus.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_release ready/sel/busy got=%b/%0d/%b want=1/0/0", bus.in_ready, bus.sel, bus.busy);
        end
    endtask

    // All channels enabled, valid held: select walks 0..7 then wraps, one accept every HOLD+2 cycles.
    task automatic test_full_rotation();
        logic       bitsArr [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [7:0] expDemux[8] = '{8'h01, 8'h00, 8'h04, 8'h08, 8'h00, 8'h00, 8'h40, 8'h00};
        int s, acc, prevAcc;
        logic [7:0] dm;
        logic b;
        prevAcc = 0;
        for (int i = 0; i < 9; i++) begin
            b = (i < 8) ? bitsArr[i] : 1'b1;
            transfer(b, 8'hFF, 8'hFF, $sformatf("rot%0d", i), s, dm, acc);
            checks++;
            if (s != (i % 8)) begin
                failures++;
                $display("[TB] FAIL rot%0d sel_order got=%0d want=%0d", i, s, i % 8);
            end
            if (i < 8) begin
                checks++;
                if (dm !== expDemux[i]) begin
                    failures++;
                    $display("[TB] FAIL rot%0d demux_out got=%h want=%h", i, dm, expDemux[i]);
                end
            end
            if (i > 0) begin
                checks++;
                if (acc - prevAcc != HOLD + 2) begin
                    failures++;
                    $display("[TB] FAIL rot%0d accept_spacing got=%0d want=%0d", i, acc - prevAcc, HOLD + 2);
                end
            end
            prevAcc = acc;
        end
    endtask

    // Sparse mask: only channels 2, 5 and 7 take part.
    task automatic test_sparse();
        int expSel[6] = '{2, 5, 7, 2, 5, 7};
        int s, acc;
        logic [7:0] dm;
        for (int i = 0; i < 6; i++) begin
            transfer(1'($urandom), 8'b1010_0100, 8'b1010_0100, $sformatf("sparse%0d", i), s, dm, acc);
            checks++;
            if (s != expSel[i]) begin
                failures++;
                $display("[TB] FAIL sparse%0d sel got=%0d want=%0d", i, s, expSel[i]);
            end
        end
    endtask

    // Empty mask stalls the pending bit; a single enabled channel then takes every bit.
    task automatic test_mask_empty();
        int s, acc;
        logic [7:0] dm;
        bus.en_mask  = 8'h00;
        bus.in_valid = 1'b1;
        bus.in_data  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0 || bus.strobe !== 8'h00) begin
                failures++;
                $display("[TB] FAIL empty%0d ready/busy/strobe got=%b/%b/%h want=0/0/00", i, bus.in_ready, bus.busy, bus.strobe);
            end
        end
        for (int i = 0; i < 3; i++) begin
            transfer(1'($urandom), 8'h01, 8'h01, $sformatf("single%0d", i), s, dm, acc);
            checks++;
            if (s != 0) begin
                failures++;
                $display("[TB] FAIL single%0d sel got=%0d want=0", i, s);
            end
        end
    endtask

    // Mask change during hold must not redirect the bit in flight.
    task automatic test_midflight();
        int s, acc;
        logic [7:0] dm;
        for (int k = 0; k < 8 && mPtr != 3; k++) begin
            transfer(1'($urandom), 8'hFF, 8'hFF, $sformatf("pre%0d", k), s, dm, acc);
        end
        transfer(1'b1, 8'hFF, 8'h80, "mid_ch3", s, dm, acc);
        checks++;
        if (s != 3) begin
            failures++;
            $display("[TB] FAIL mid_ch3 sel got=%0d want=3", s);
        end
        transfer(1'b1, 8'h80, 8'h80, "mid_ch7", s, dm, acc);
        checks++;
        if (s != 7) begin
            failures++;
            $display("[TB] FAIL mid_ch7 sel got=%0d want=7", s);
        end
    endtask

    // Reset one cycle into hold drops the bit; the pointer restarts at channel 0.
    task automatic test_reset_during_hold();
        int s, acc, n;
        logic [7:0] dm;
        transfer(1'($urandom), 8'hFF, 8'hFF, "pre_abort", s, dm, acc);
        bus.en_mask  = 8'hFF;
        bus.in_valid = 1'b1;
        bus.in_data  = 1'b1;
        #1;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1 || bus.d !== 1'b1) begin
            failures++;
            $display("[TB] FAIL abort_inflight busy/d got=%b/%b want=1/1", bus.busy, bus.d);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.sel !== 3'd0 || bus.d !== 1'b0 || bus.busy !== 1'b0 || bus.strobe !== 8'h00) begin
            failures++;
            $display("[TB] FAIL abort_clear sel/d/busy/strobe got=%0d/%b/%b/%h want=0/0/0/00", bus.sel, bus.d, bus.busy, bus.strobe);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (bus.strobe !== 8'h00) begin
                failures++;
                $display("[TB] FAIL abort_nostrobe%0d strobe got=%h want=00", i, bus.strobe);
            end
        end
        rst_n = 1'b1;
        mPtr  = 0;
        transfer(1'($urandom), 8'b0011_0000, 8'b0011_0000, "post_abort", s, dm, acc);
        checks++;
        if (s != 4) begin
            failures++;
            $display("[TB] FAIL post_abort sel got=%0d want=4", s);
        end
    endtask

    // Sequence of scenarios followed by the summary.
    initial begin
        bus.en_mask  = 8'h00;
        bus.in_valid = 1'b0;
        bus.in_data  = 1'b0;
        test_reset();
        test_full_rotation();
        test_sparse();
        test_mask_empty();
        test_midflight();
        test_reset_during_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
